// File: rtl/rc4_sbox_ctrl.sv
// rtl/rc4_sbox_ctrl.sv - RC4 sequencer over 4-bit symbols driving a 16x4 nibble S-box memory
//
// Purpose:
//   Owns the S-box port set. Runs init (S[i]=i), the key schedule and then
//   keystream generation, handing one keystream nibble at a time to the
//   consumer on a valid/ready handshake.
//
// Configuration macro:
//   RC4_DROP_EN - when defined, the first DROP_N generated nibbles after the
//                 key schedule are discarded instead of delivered.
//
// Parameters:
//   KEY_NIBBLES  key length in nibbles (1..16)
//   DROP_N       nibbles discarded after the key schedule (RC4_DROP_EN only, 0..255)
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   start, stop                   begin keying (IDLE only) / abort to IDLE (wins over start)
//   key                           key, nibble k = key[4k+3:4k], latched on accepted start
//   busy                          high outside IDLE
//   ks_valid, ks_ready, ks_data   keystream nibble handshake
//   sbox_en                       1 = read cycle, 0 = write both ports
//   sbox_addo, sbox_out           read address / read data (one cycle after address)
//   sbox_addi1, sbox_in1          write port 1
//   sbox_addi2, sbox_in2          write port 2 (wins on address collision)

module rc4_sbox_ctrl #(
  parameter int KEY_NIBBLES = 8,
  parameter int DROP_N      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [4*KEY_NIBBLES-1:0] key,
  output logic                     busy,
  output logic                     ks_valid,
  input  logic                     ks_ready,
  output logic [3:0]               ks_data,
  output logic                     sbox_en,
  output logic [3:0]               sbox_addo,
  input  logic [3:0]               sbox_out,
  output logic [3:0]               sbox_addi1,
  output logic [3:0]               sbox_in1,
  output logic [3:0]               sbox_addi2,
  output logic [3:0]               sbox_in2
);

  // Reject out-of-range configurations at elaboration time.
  if (KEY_NIBBLES < 1 || KEY_NIBBLES > 16) begin : g_bad_key_nibbles
    $error("rc4_sbox_ctrl: KEY_NIBBLES must be 1..16");
  end
  if (DROP_N < 0 || DROP_N > 255) begin : g_bad_drop_n
    $error("rc4_sbox_ctrl: DROP_N must be 0..255");
  end

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    K_RDI,
    K_RDJ,
    K_SWP,
    P_RDI,
    P_RDJ,
    P_SWP,
    P_RDT,
    P_CAP,
    P_HOLD
  } state_t;

  localparam logic [3:0] KIDX_LAST = 4'(KEY_NIBBLES - 1);

  state_t                   state_q, state_d;
  logic [3:0]               i_q, i_d;
  logic [3:0]               j_q, j_d;
  logic [3:0]               kidx_q, kidx_d;
  logic [3:0]               si_q, si_d;
  logic [3:0]               t_q, t_d;
  logic [4*KEY_NIBBLES-1:0] key_q, key_d;
  logic [3:0]               ks_data_q, ks_data_d;
  logic                     ks_valid_q, ks_valid_d;
  logic [3:0]               key_sel;
  logic [3:0]               jn;

`ifdef RC4_DROP_EN
  localparam logic [7:0] DROP_INIT = 8'(DROP_N);
  logic [7:0] drop_q, drop_d;
`endif

  assign busy     = (state_q != IDLE);
  assign ks_valid = ks_valid_q;
  assign ks_data  = ks_data_q;

  // kidx never exceeds KEY_NIBBLES-1, so the slice stays inside key_q.
  assign key_sel = key_q[{kidx_q, 2'b00} +: 4];
  // KSA: sbox_out holds S[i] while in K_RDJ.
  assign jn      = j_q + sbox_out + key_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      si_q       <= '0;
      t_q        <= '0;
      key_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
`ifdef RC4_DROP_EN
      drop_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kidx_q     <= kidx_d;
      si_q       <= si_d;
      t_q        <= t_d;
      key_q      <= key_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
`ifdef RC4_DROP_EN
      drop_q     <= drop_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    kidx_d     = kidx_q;
    si_d       = si_q;
    t_d        = t_q;
    key_d      = key_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
`ifdef RC4_DROP_EN
    drop_d     = drop_q;
`endif
    sbox_en    = 1'b1;
    sbox_addo  = 4'd0;
    sbox_addi1 = 4'd0;
    sbox_in1   = 4'd0;
    sbox_addi2 = 4'd0;
    sbox_in2   = 4'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          key_d   = key;
          i_d     = 4'd0;
        end
      end

      // Two entries per cycle: S[2i]=2i, S[2i+1]=2i+1.
      INIT: begin
        sbox_en    = 1'b0;
        sbox_addi1 = {i_q[2:0], 1'b0};
        sbox_in1   = {i_q[2:0], 1'b0};
        sbox_addi2 = {i_q[2:0], 1'b1};
        sbox_in2   = {i_q[2:0], 1'b1};
        i_d        = i_q + 4'd1;
        if (i_q == 4'd7) begin
          state_d = K_RDI;
          i_d     = 4'd0;
          j_d     = 4'd0;
          kidx_d  = 4'd0;
        end
      end

      K_RDI: begin
        sbox_addo = i_q;
        state_d   = K_RDJ;
      end

      K_RDJ: begin
        si_d      = sbox_out;
        j_d       = jn;
        sbox_addo = jn;
        state_d   = K_SWP;
      end

      // sbox_out now holds S[j]; swap S[i] and S[j].
      K_SWP: begin
        sbox_en    = 1'b0;
        sbox_addi1 = i_q;
        sbox_in1   = sbox_out;
        sbox_addi2 = j_q;
        sbox_in2   = si_q;
        kidx_d     = (kidx_q == KIDX_LAST) ? 4'd0 : kidx_q + 4'd1;
        if (i_q == 4'd15) begin
          state_d = P_RDI;
          i_d     = 4'd0;
          j_d     = 4'd0;
`ifdef RC4_DROP_EN
          drop_d  = DROP_INIT;
`endif
        end else begin
          state_d = K_RDI;
          i_d     = i_q + 4'd1;
        end
      end

      P_RDI: begin
        sbox_addo = i_q + 4'd1;
        i_d       = i_q + 4'd1;
        state_d   = P_RDJ;
      end

      P_RDJ: begin
        si_d      = sbox_out;
        j_d       = j_q + sbox_out;
        sbox_addo = j_q + sbox_out;
        state_d   = P_SWP;
      end

      // Output index uses pre-swap values; the sum is the same after the swap.
      P_SWP: begin
        sbox_en    = 1'b0;
        sbox_addi1 = i_q;
        sbox_in1   = sbox_out;
        sbox_addi2 = j_q;
        sbox_in2   = si_q;
        t_d        = si_q + sbox_out;
        state_d    = P_RDT;
      end

      // Read issued after the swap edge, so it sees the updated table.
      P_RDT: begin
        sbox_addo = t_q;
        state_d   = P_CAP;
      end

      P_CAP: begin
`ifdef RC4_DROP_EN
        if (drop_q != 8'd0) begin
          drop_d  = drop_q - 8'd1;
          state_d = P_RDI;
        end else begin
          ks_data_d  = sbox_out;
          ks_valid_d = 1'b1;
          state_d    = P_HOLD;
        end
`else
        ks_data_d  = sbox_out;
        ks_valid_d = 1'b1;
        state_d    = P_HOLD;
`endif
      end

      P_HOLD: begin
        if (ks_ready) begin
          ks_valid_d = 1'b0;
          state_d    = P_RDI;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort: the port decode above still reflects the current state, so a
    // write already presented this cycle completes on this edge.
    if (stop) begin
      state_d    = IDLE;
      ks_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// tb/tb_rc4_sbox_ctrl.sv - directed self-checking bench for rc4_sbox_ctrl
module tb_rc4_sbox_ctrl;

`ifdef RC4_DROP_EN
  localparam int DROP = 16;
`else
  localparam int DROP = 0;
`endif
  localparam int FIRST_LAT = 61 + 5 * DROP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] key = 32'h0;
  logic        busy;
  logic        ks_valid;
  logic        ks_ready = 1'b0;
  logic [3:0]  ks_data;
  logic        sbox_en;
  logic [3:0]  sbox_addo;
  logic [3:0]  sbox_out;
  logic [3:0]  sbox_addi1;
  logic [3:0]  sbox_in1;
  logic [3:0]  sbox_addi2;
  logic [3:0]  sbox_in2;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [16];
  logic [3:0] m_ksa [16];
  logic [3:0] m_ks [64];

  rc4_sbox_ctrl #(.KEY_NIBBLES(8), .DROP_N(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .key(key),
    .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .sbox_en(sbox_en), .sbox_addo(sbox_addo), .sbox_out(sbox_out),
    .sbox_addi1(sbox_addi1), .sbox_in1(sbox_in1),
    .sbox_addi2(sbox_addi2), .sbox_in2(sbox_in2)
  );

  always #5 clk = ~clk;

  // S-box memory: registered read, dual write on en=0 with port 2 last.
  always @(posedge clk) begin
    if (sbox_en) begin
      sbox_out <= mem[sbox_addo];
    end else begin
      mem[sbox_addi1] <= sbox_in1;
      mem[sbox_addi2] <= sbox_in2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Plain nibble RC4 reference: KSA result in m_ksa, keystream in m_ks.
  task automatic model_run(input logic [31:0] k);
    logic [3:0] s [16];
    logic [3:0] i, j, t, tmp;
    for (int a = 0; a < 16; a++) s[a] = 4'(a);
    j = 4'd0;
    for (int a = 0; a < 16; a++) begin
      j = j + s[a] + k[4*(a%8) +: 4];
      tmp = s[a]; s[a] = s[j]; s[j] = tmp;
    end
    for (int a = 0; a < 16; a++) m_ksa[a] = s[a];
    i = 4'd0;
    j = 4'd0;
    for (int n = 0; n < 64; n++) begin
      i = i + 4'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      m_ks[n] = s[t];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL reset_ks_valid: got %b expected 0", ks_valid); end
    checks++; if (ks_data !== 4'h0) begin errors++; $display("FAIL reset_ks_data: got %h expected 0", ks_data); end
    checks++; if (sbox_en !== 1'b1) begin errors++; $display("FAIL reset_sbox_en: got %b expected 1", sbox_en); end
    checks++; if (sbox_addo !== 4'h0) begin errors++; $display("FAIL reset_addo: got %h expected 0", sbox_addo); end
    @(negedge clk);
    rst_n = 1'b1;
    // Asynchronous reset in the middle of the key schedule.
    start_run(32'h0123_4567);
    for (int c = 0; c < 20; c++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midksa_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ks_valid: got %b expected 0", ks_valid); end
    checks++; if (sbox_en !== 1'b1) begin errors++; $display("FAIL async_rst_sbox_en: got %b expected 1", sbox_en); end
    checks++; if (sbox_addo !== 4'h0) begin errors++; $display("FAIL async_rst_addo: got %h expected 0", sbox_addo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init_ksa();
    logic [3:0] e;
    int wl;
    model_run(32'h0123_4567);
    start_run(32'h0123_4567);
    for (int k = 0; k < 8; k++) begin
      e = 4'(2 * k);
      checks++; if (sbox_en !== 1'b0) begin errors++; $display("FAIL init_en[%0d]: got %b expected 0", k, sbox_en); end
      checks++; if ({sbox_addi1, sbox_in1} !== {e, e}) begin errors++; $display("FAIL init_port1[%0d]: got %h/%h expected %h/%h", k, sbox_addi1, sbox_in1, e, e); end
      checks++; if ({sbox_addi2, sbox_in2} !== {e + 4'd1, e + 4'd1}) begin errors++; $display("FAIL init_port2[%0d]: got %h/%h expected %h/%h", k, sbox_addi2, sbox_in2, e + 4'd1, e + 4'd1); end
      tick();
    end
    checks++; if ({sbox_en, sbox_addo} !== {1'b1, 4'h0}) begin errors++; $display("FAIL ksa_first_read: got en=%b addo=%h expected en=1 addo=0", sbox_en, sbox_addo); end
    wl = 0;
    for (int c = 0; c < 48; c++) begin
      if (!sbox_en) wl++;
      tick();
    end
    checks++; if (wl !== 16) begin errors++; $display("FAIL ksa_write_cycles: got %0d expected 16", wl); end
    for (int a = 0; a < 16; a++) begin
      checks++; if (mem[a] !== m_ksa[a]) begin errors++; $display("FAIL ksa_sbox[%0d]: got %h expected %h", a, mem[a], m_ksa[a]); end
    end
    checks++; if ({busy, ks_valid} !== 2'b10) begin errors++; $display("FAIL ksa_end_flags: got busy=%b valid=%b expected busy=1 valid=0", busy, ks_valid); end
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ksa_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stream();
    int first, acc, wl, last, cyc;
    model_run(32'h0123_4567);
    ks_ready = 1'b1;
    start_run(32'h0123_4567);
    first = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ks_valid) begin first = n; break; end
    end
    checks++; if (first !== FIRST_LAT) begin errors++; $display("FAIL first_valid_latency: got %0d expected %0d", first, FIRST_LAT); end
    acc = 0; wl = 0; last = 0; cyc = 0;
    while (acc < 32 && cyc < 400) begin
      if (!sbox_en) wl++;
      if (ks_valid && ks_ready) begin
        checks++; if (ks_data !== m_ks[acc + DROP]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", acc, ks_data, m_ks[acc + DROP]); end
        if (acc > 0) begin
          checks++; if (cyc - last !== 6) begin errors++; $display("FAIL stream_spacing[%0d]: got %0d expected 6", acc, cyc - last); end
        end
        last = cyc;
        acc++;
      end
      tick();
      cyc++;
    end
    checks++; if (acc !== 32) begin errors++; $display("FAIL stream_count: got %0d expected 32", acc); end
    checks++; if (wl !== 31) begin errors++; $display("FAIL stream_write_cycles: got %0d expected 31", wl); end
  endtask

  task automatic test_backpressure();
    logic [3:0] d;
    int n, acc, cyc;
    ks_ready = 1'b0;
    n = 0;
    while (!ks_valid && n < 10) begin tick(); n++; end
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_arrive: got %b expected 1", ks_valid); end
    d = ks_data;
    checks++; if (d !== m_ks[32 + DROP]) begin errors++; $display("FAIL bp_data: got %h expected %h", d, m_ks[32 + DROP]); end
    for (int h = 0; h < 20; h++) begin
      if (h == 5) begin key = 32'h0; start = 1'b1; end
      if (h == 6) start = 1'b0;
      checks++; if ({ks_valid, ks_data, sbox_en} !== {1'b1, d, 1'b1}) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h en=%b expected 1/%h/1", h, ks_valid, ks_data, sbox_en, d); end
      tick();
    end
    ks_ready = 1'b1;
    acc = 32; cyc = 0;
    while (acc < 36 && cyc < 100) begin
      if (ks_valid && ks_ready) begin
        checks++; if (ks_data !== m_ks[acc + DROP]) begin errors++; $display("FAIL bp_resume[%0d]: got %h expected %h", acc, ks_data, m_ks[acc + DROP]); end
        acc++;
      end
      tick();
      cyc++;
    end
    checks++; if (acc !== 36) begin errors++; $display("FAIL bp_resume_count: got %0d expected 36", acc); end
    ks_ready = 1'b0;
    n = 0;
    while (!ks_valid && n < 10) begin tick(); n++; end
    checks++; if (ks_data !== m_ks[36 + DROP]) begin errors++; $display("FAIL bp_next_data: got %h expected %h", ks_data, m_ks[36 + DROP]); end
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checks++; if ({busy, ks_valid} !== 2'b00) begin errors++; $display("FAIL stop_clears: got busy=%b valid=%b expected 0/0", busy, ks_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({sbox_en, sbox_addo} !== {1'b1, 4'h0}) begin errors++; $display("FAIL idle_port[%0d]: got en=%b addo=%h expected 1/0", c, sbox_en, sbox_addo); end
    end
  endtask

  task automatic test_stop_in_krdj();
    int first, acc, cyc;
    ks_ready = 1'b1;
    start_run(32'h0123_4567);
    for (int c = 0; c < 9; c++) tick();
    // First K_RDJ: j = 0 + S[0](=0) + key nibble 0 (=7).
    checks++; if ({sbox_en, sbox_addo} !== {1'b1, 4'h7}) begin errors++; $display("FAIL krdj_addr: got en=%b addo=%h expected 1/7", sbox_en, sbox_addo); end
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    checks++; if ({busy, sbox_en, sbox_addo} !== {1'b0, 1'b1, 4'h0}) begin errors++; $display("FAIL stop_wins: got busy=%b en=%b addo=%h expected 0/1/0", busy, sbox_en, sbox_addo); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_stays_idle: got %b expected 0", busy); end
    model_run(32'hFFFF_FFFF);
    start_run(32'hFFFF_FFFF);
    first = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ks_valid) begin first = n; break; end
    end
    checks++; if (first !== FIRST_LAT) begin errors++; $display("FAIL rerun_latency: got %0d expected %0d", first, FIRST_LAT); end
    acc = 0; cyc = 0;
    while (acc < 8 && cyc < 200) begin
      if (ks_valid && ks_ready) begin
        checks++; if (ks_data !== m_ks[acc + DROP]) begin errors++; $display("FAIL rerun_data[%0d]: got %h expected %h", acc, ks_data, m_ks[acc + DROP]); end
        acc++;
      end
      tick();
      cyc++;
    end
    checks++; if (acc !== 8) begin errors++; $display("FAIL rerun_count: got %0d expected 8", acc); end
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_ksa();
    test_stream();
    test_backpressure();
    test_stop_in_krdj();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
